mem_arbiter: RTL and testbench

//  Shares one single-port word memory (rom/ram, registered read data) between the
//  CPU instruction-fetch port (if_*) and the load/store port (ls_*). One access
//  is outstanding at a time. Load/store has priority; a starvation guard keeps

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_arb_fair.sv | 44 ++++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
package mem_pkg;

    localparam int unsigned MEM_AW = 7;
    localparam int unsigned MEM_DW = 32;

    // Port identifiers used for the read-response owner
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arb_fair.sv
// Winner select with a starvation guard: load/store wins unless fetch has
// waited through MAX_BURST consecutive load/store grants.
module mem_arb_fair
    import mem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic ls_req,
    input  logic if_gnt,
    input  logic ls_gnt,
    output logic pick_ls
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_d;

    // Count ls grants that overtook a waiting fetch; saturate at the limit
    always_comb begin
        burst_d = burst_q;
        if (!if_req || if_gnt) begin
            burst_d = '0;
        end else if (ls_gnt && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + BW'(1);
        end
    end

    // Burst counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    assign pick_ls = ls_req && !(if_req && (burst_q == BURST_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port registered-read memory between instruction fetch
// and load/store; one read in flight at a time, stores acked next cycle.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned AW        = MEM_AW,
    parameter int unsigned DW        = MEM_DW,
    parameter int unsigned LAT       = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned BEW = DW / 8;
    localparam int unsigned LW  = $clog2(LAT + 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(LAT);

    arb_state_e     state_q, state_d;
    logic           owner_q, owner_d;
    logic [LW-1:0]  lat_q, lat_d;
    logic           if_rvalid_q, if_rvalid_d;
    logic           ls_rvalid_q, ls_rvalid_d;
    logic [DW-1:0]  if_rdata_q, if_rdata_d;
    logic [DW-1:0]  ls_rdata_q, ls_rdata_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [BEW-1:0] be_q, be_d;
    logic           accept;
    logic           pick_ls;

    mem_arb_fair #(
        .MAX_BURST (MAX_BURST)
    ) u_fair (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .ls_req  (ls_req),
        .if_gnt  (if_gnt),
        .ls_gnt  (ls_gnt),
        .pick_ls (pick_ls)
    );

    // Next state, grants and memory strobes; address/data hold when idle
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        accept      = 1'b0;
        if_gnt      = 1'b0;
        ls_gnt      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = be_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;

        case (state_q)
            ARB_IDLE: accept = 1'b1;
            ARB_WAIT: begin
                lat_d = lat_q - LW'(1);
                // Last wait cycle: memory data is valid now, register it
                if (lat_q == LW'(1)) begin
                    state_d = ARB_IDLE;
                    if (owner_q == PORT_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
        endcase

        if (accept && !rst) begin
            if (pick_ls) begin
                ls_gnt    = 1'b1;
                mem_en    = 1'b1;
                mem_we    = ls_we;
                mem_be    = ls_be;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
                addr_d    = ls_addr;
                wdata_d   = ls_wdata;
                be_d      = ls_be;
                if (ls_we) begin
                    ls_rvalid_d = 1'b1;
                    ls_rdata_d  = '0;
                end else begin
                    state_d = ARB_WAIT;
                    owner_d = PORT_LS;
                    lat_d   = LAT_INIT;
                end
            end else if (if_req) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr;
                addr_d   = if_addr;
                state_d  = ARB_WAIT;
                owner_d  = PORT_IF;
                lat_d    = LAT_INIT;
            end
        end

        if (rst) begin
            mem_be    = '0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // State and response registers; reset abandons any read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= PORT_IF;
            lat_q       <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rvalid = ls_rvalid_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: LAT=1 instance checked every cycle against a
// timestamp/queue model, LAT=3 instance for latency and reset-abort cases.
module tb_mem_arbiter;

    localparam int MAXB = 4;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- LAT=1 instance ----------------
    logic        rst1;
    logic        if1_req, if1_gnt, if1_rvalid;
    logic [6:0]  if1_addr;
    logic [31:0] if1_rdata;
    logic        ls1_req, ls1_we, ls1_gnt, ls1_rvalid;
    logic [3:0]  ls1_be;
    logic [6:0]  ls1_addr;
    logic [31:0] ls1_wdata, ls1_rdata;
    logic        m1_en, m1_we;
    logic [3:0]  m1_be;
    logic [6:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;

    mem_arbiter #(.AW(7), .DW(32), .LAT(LAT1), .MAX_BURST(MAXB)) dut1 (
        .clk(clk), .rst(rst1),
        .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt),
        .if_rvalid(if1_rvalid), .if_rdata(if1_rdata),
        .ls_req(ls1_req), .ls_we(ls1_we), .ls_be(ls1_be), .ls_addr(ls1_addr),
        .ls_wdata(ls1_wdata), .ls_gnt(ls1_gnt), .ls_rvalid(ls1_rvalid), .ls_rdata(ls1_rdata),
        .mem_en(m1_en), .mem_we(m1_we), .mem_be(m1_be), .mem_addr(m1_addr),
        .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
    );

    // ---------------- LAT=3 instance ----------------
    logic        rst3;
    logic        if3_req, if3_gnt, if3_rvalid;
    logic [6:0]  if3_addr;
    logic [31:0] if3_rdata;
    logic        ls3_req, ls3_we, ls3_gnt, ls3_rvalid;
    logic [3:0]  ls3_be;
    logic [6:0]  ls3_addr;
    logic [31:0] ls3_wdata, ls3_rdata;
    logic        m3_en, m3_we;
    logic [3:0]  m3_be;
    logic [6:0]  m3_addr;
    logic [31:0] m3_wdata, m3_rdata;

    mem_arbiter #(.AW(7), .DW(32), .LAT(3), .MAX_BURST(MAXB)) dut3 (
        .clk(clk), .rst(rst3),
        .if_req(if3_req), .if_addr(if3_addr), .if_gnt(if3_gnt),
        .if_rvalid(if3_rvalid), .if_rdata(if3_rdata),
        .ls_req(ls3_req), .ls_we(ls3_we), .ls_be(ls3_be), .ls_addr(ls3_addr),
        .ls_wdata(ls3_wdata), .ls_gnt(ls3_gnt), .ls_rvalid(ls3_rvalid), .ls_rdata(ls3_rdata),
        .mem_en(m3_en), .mem_we(m3_we), .mem_be(m3_be), .mem_addr(m3_addr),
        .mem_wdata(m3_wdata), .mem_rdata(m3_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] a;
        a = 8'(i);
        return {8'hA5, a, ~a, 8'(i * 3)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Memories: registered read, reloaded with known contents during reset
    logic [31:0] mem1 [128];
    logic [31:0] pipe1;
    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 128; i++) mem1[i] <= init_word(i);
        end else if (m1_en) begin
            if (m1_we) begin
                for (int b = 0; b < 4; b++)
                    if (m1_be[b]) mem1[m1_addr][b*8 +: 8] <= m1_wdata[b*8 +: 8];
            end else begin
                pipe1 <= mem1[m1_addr];
            end
        end
    end
    assign m1_rdata = pipe1;

    logic [31:0] mem3 [128];
    logic [31:0] p3a, p3b, p3c;
    always @(posedge clk) begin
        p3b <= p3a;
        p3c <= p3b;
        if (rst3) begin
            for (int i = 0; i < 128; i++) mem3[i] <= init_word(i);
        end else if (m3_en && !m3_we) begin
            p3a <= mem3[m3_addr];
        end
    end
    assign m3_rdata = p3c;

    // ---------------- reference model for dut1 ----------------
    typedef struct {
        int          due;
        bit          ls;
        logic [31:0] data;
    } resp_t;

    resp_t       m_q[$];
    resp_t       m_r;
    logic [31:0] m_shadow [128];
    int          m_cyc     = 0;
    int          m_free_at = 0;
    int          m_burst   = 0;
    bit          m_prev_rst = 1'b0;
    bit          m_idle, m_ls_w, m_if_w, m_exp_ifv, m_exp_lsv;
    logic [31:0] m_exp_data;
    logic [6:0]  m_last_addr = '0;

    always @(negedge clk) begin
        m_exp_ifv  = 1'b0;
        m_exp_lsv  = 1'b0;
        m_exp_data = '0;
        if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
            m_r = m_q.pop_front();
            if (m_r.ls) m_exp_lsv = 1'b1;
            else        m_exp_ifv = 1'b1;
            m_exp_data = m_r.data;
        end
        chk("model_if_rvalid", if1_rvalid, m_exp_ifv);
        chk("model_ls_rvalid", ls1_rvalid, m_exp_lsv);
        if (m_exp_ifv) chk("model_if_rdata", if1_rdata, m_exp_data);
        if (m_exp_lsv) chk("model_ls_rdata", ls1_rdata, m_exp_data);

        if (rst1) begin
            chk("model_rst_strobes", {if1_gnt, ls1_gnt, m1_en, m1_we}, 4'b0000);
            chk("model_rst_addr", m1_addr, 7'd0);
            if (m_prev_rst) chk("model_rst_rdata", {if1_rdata, ls1_rdata}, 64'd0);
            m_q.delete();
            m_burst     = 0;
            m_free_at   = m_cyc + 1;
            m_last_addr = '0;
            for (int i = 0; i < 128; i++) m_shadow[i] = init_word(i);
        end else begin
            m_idle = (m_cyc >= m_free_at);
            m_ls_w = m_idle && ls1_req && !(if1_req && m_burst >= MAXB);
            m_if_w = m_idle && if1_req && !m_ls_w;
            chk("model_ls_gnt", ls1_gnt, m_ls_w);
            chk("model_if_gnt", if1_gnt, m_if_w);
            chk("model_mem_en", m1_en, m_ls_w || m_if_w);
            chk("model_mem_we", m1_we, m_ls_w && ls1_we);
            if (m_ls_w)      m_last_addr = ls1_addr;
            else if (m_if_w) m_last_addr = if1_addr;
            chk("model_mem_addr", m1_addr, m_last_addr);

            if (m_ls_w && ls1_we) begin
                chk("model_mem_wdata", m1_wdata, ls1_wdata);
                chk("model_mem_be", m1_be, ls1_be);
                for (int b = 0; b < 4; b++)
                    if (ls1_be[b]) m_shadow[ls1_addr][b*8 +: 8] = ls1_wdata[b*8 +: 8];
                m_q.push_back('{due: m_cyc + 1, ls: 1'b1, data: 32'd0});
            end else if (m_ls_w) begin
                m_q.push_back('{due: m_cyc + LAT1 + 1, ls: 1'b1, data: m_shadow[ls1_addr]});
                m_free_at = m_cyc + LAT1 + 1;
            end else if (m_if_w) begin
                m_q.push_back('{due: m_cyc + LAT1 + 1, ls: 1'b0, data: m_shadow[if1_addr]});
                m_free_at = m_cyc + LAT1 + 1;
            end

            if (!if1_req || m_if_w)          m_burst = 0;
            else if (m_ls_w && m_burst < MAXB) m_burst = m_burst + 1;
        end
        m_prev_rst = rst1;
        m_cyc++;
    end

    // ---------------- stimulus ----------------
    int n_ls, n_rv;
    bit got_if, g_if, g_ls;

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        if1_req = 0; if1_addr = '0; ls1_req = 0; ls1_we = 0; ls1_be = '0; ls1_addr = '0; ls1_wdata = '0;
        if3_req = 0; if3_addr = '0; ls3_req = 0; ls3_we = 0; ls3_be = '0; ls3_addr = '0; ls3_wdata = '0;

        repeat (3) tick();
        look();
        chk("rst_if_rvalid", if1_rvalid, 1'b0);
        chk("rst_mem_en", m1_en, 1'b0);
        chk("rst_if_rdata", if1_rdata, 32'd0);

        // single fetch, LAT=1
        tick(); rst1 = 0; rst3 = 0; if1_req = 1; if1_addr = 7'd5;
        look(); chk("t1_if_gnt", if1_gnt, 1'b1); chk("t1_mem_addr", m1_addr, 7'd5);
        chk("t1_ls_gnt", ls1_gnt, 1'b0);
        tick(); if1_req = 0;
        look(); chk("t1_rvalid_c1", if1_rvalid, 1'b0);
        tick(); look();
        chk("t1_rvalid_c2", if1_rvalid, 1'b1); chk("t1_rdata", if1_rdata, 32'hA505_FA0F);
        chk("t1_ls_rvalid", ls1_rvalid, 1'b0);
        tick(); look(); chk("t1_rvalid_c3", if1_rvalid, 1'b0);

        // simultaneous fetch and load: load first
        tick(); if1_req = 1; if1_addr = 7'd6; ls1_req = 1; ls1_we = 0; ls1_addr = 7'd7;
        look(); chk("t2_ls_first", ls1_gnt, 1'b1); chk("t2_if_waits", if1_gnt, 1'b0);
        tick(); ls1_req = 0; look();
        tick(); look();
        chk("t2_ls_rvalid", ls1_rvalid, 1'b1); chk("t2_ls_rdata", ls1_rdata, 32'hA507_F815);
        chk("t2_if_gnt", if1_gnt, 1'b1); chk("t2_if_addr", m1_addr, 7'd6);
        tick(); if1_req = 0; look();
        tick(); look();
        chk("t2_if_rvalid", if1_rvalid, 1'b1); chk("t2_if_rdata", if1_rdata, 32'hA506_F912);

        // starvation guard, twice to show the counter restarts
        for (int rep = 0; rep < 2; rep++) begin
            n_ls = 0; got_if = 0;
            for (int k = 0; k < 24 && !got_if; k++) begin
                tick(); if1_req = 1; if1_addr = 7'd9; ls1_req = 1; ls1_we = 0; ls1_addr = 7'd2;
                look();
                if (ls1_gnt) n_ls++;
                if (if1_gnt) got_if = 1;
            end
            chk("burst_ls_grants", n_ls, 4);
            chk("burst_if_wins", got_if, 1'b1);
        end
        repeat (3) begin tick(); if1_req = 0; ls1_req = 0; look(); end

        // back-to-back half-word stores
        for (int k = 0; k < 3; k++) begin
            tick(); ls1_req = 1; ls1_we = 1; ls1_be = 4'b0011; ls1_addr = 7'(8 + k);
            ls1_wdata = 32'h5555_1234 + 32'(k);
            look(); chk("st_gnt", ls1_gnt, 1'b1); chk("st_mem_we", m1_we, 1'b1);
            if (k > 0) begin chk("st_ack", ls1_rvalid, 1'b1); chk("st_ack_data", ls1_rdata, 32'd0); end
        end
        tick(); ls1_req = 0; ls1_we = 0;
        look(); chk("st_ack_last", ls1_rvalid, 1'b1); chk("st_ack_last_data", ls1_rdata, 32'd0);
        tick(); ls1_req = 1; ls1_addr = 7'd8;
        look(); chk("rb_gnt", ls1_gnt, 1'b1);
        tick(); ls1_req = 0; look();
        tick(); look();
        chk("rb_rvalid", ls1_rvalid, 1'b1); chk("rb_data", ls1_rdata, 32'hA508_1234);

        // LAT=3 load
        tick(); ls3_req = 1; ls3_we = 0; ls3_addr = 7'd3;
        look(); chk("l3_gnt", ls3_gnt, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick(); ls3_req = 0; look(); chk("l3_wait_no_rvalid", ls3_rvalid, 1'b0);
        end
        tick(); look();
        chk("l3_rvalid", ls3_rvalid, 1'b1); chk("l3_rdata", ls3_rdata, 32'hA503_FC09);

        // LAT=3 load aborted by reset in its second wait cycle
        tick(); ls3_req = 1; ls3_addr = 7'd4;
        look(); chk("r3_gnt", ls3_gnt, 1'b1);
        tick(); ls3_req = 0; look();
        tick(); rst3 = 1;
        look(); chk("r3_rst_no_strobe", {ls3_gnt, if3_gnt, m3_en, m3_we}, 4'b0000);
        tick(); look();
        chk("r3_outputs_zero", |{if3_gnt, ls3_gnt, if3_rvalid, ls3_rvalid, if3_rdata, ls3_rdata,
                                 m3_en, m3_we, m3_be, m3_addr, m3_wdata}, 1'b0);
        tick(); rst3 = 0; ls3_req = 1; ls3_addr = 7'd10;
        look(); chk("r3_first_gnt", ls3_gnt, 1'b1); chk("r3_abandoned", ls3_rvalid, 1'b0);
        n_rv = 0;
        for (int k = 0; k < 3; k++) begin
            tick(); ls3_req = 0; look();
            if (ls3_rvalid) n_rv++;
        end
        chk("r3_no_stray_rvalid", n_rv, 0);
        tick(); look();
        chk("r3_new_rvalid", ls3_rvalid, 1'b1); chk("r3_new_rdata", ls3_rdata, 32'hA50A_F51E);

        // randomized traffic on dut1, checked by the model every cycle
        g_if = 0; g_ls = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!if1_req || g_if) begin
                if ($urandom_range(0, 2) != 0) begin
                    if1_req = 1; if1_addr = 7'($urandom_range(0, 15));
                end else begin
                    if1_req = 0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                if1_req = 0;
            end
            if (!ls1_req || g_ls) begin
                if ($urandom_range(0, 2) != 0) begin
                    ls1_req   = 1;
                    ls1_we    = 1'($urandom_range(0, 1));
                    ls1_be    = 4'($urandom_range(1, 15));
                    ls1_addr  = 7'($urandom_range(0, 15));
                    ls1_wdata = $urandom;
                end else begin
                    ls1_req = 0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                ls1_req = 0;
            end
            look();
            g_if = if1_gnt;
            g_ls = ls1_gnt;
        end
        repeat (6) begin tick(); if1_req = 0; ls1_req = 0; look(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
